vc_msg_serializer: RTL and testbench

//  Wide-to-narrow message serializer on val/rdy interfaces. Sits directly

---
 rtl/vc_serdes_pkg.sv | 19 +
 rtl/vc_msg_serializer_ctrl.sv | 67 ++++++
 rtl/vc_msg_serializer.sv | 75 +++++++
 tb/tb_vc_msg_serializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vc_serdes_pkg.sv
// Shared definitions for the val/rdy message serializer and its planned
// deserializer counterpart: state encoding and chunk-count arithmetic.
package vc_serdes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } serdes_state_e;

    function automatic int unsigned serdes_nchunks(input int unsigned in_nbits,
                                                   input int unsigned out_nbits);
        return (in_nbits + out_nbits - 1) / out_nbits;
    endfunction

    function automatic int unsigned serdes_cnt_nbits(input int unsigned nchunks);
        return ($clog2(nchunks) > 1) ? $clog2(nchunks) : 1;
    endfunction

endpackage

// File: rtl/vc_msg_serializer_ctrl.sv
// Control half of the serializer: IDLE/SEND state, chunk counter, handshake
// outputs and the load/shift enables for the datapath in the top module.
module vc_msg_serializer_ctrl
    import vc_serdes_pkg::*;
#(
    parameter int unsigned p_nchunks   = 4,
    parameter int unsigned p_cnt_nbits = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_val,
    output logic in_rdy,
    output logic out_val,
    input  logic out_rdy,
    output logic out_last,
    output logic busy,
    output logic load_en,
    output logic shift_en
);

    localparam logic [p_cnt_nbits-1:0] c_last_cnt = p_cnt_nbits'(p_nchunks - 1);

    serdes_state_e          state_q, state_d;
    logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   do_in;
    logic                   do_out;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_val  = (state_q == ST_SEND);
        out_last = out_val && (cnt_q == c_last_cnt);
        busy     = out_val;
        // Pipelined accept: a new message may load while the last chunk leaves.
        in_rdy   = !out_val || (out_last && out_rdy);
        do_in    = in_val && in_rdy;
        do_out   = out_val && out_rdy;
        load_en  = do_in;
        shift_en = do_out && !do_in;

        if (do_in) begin
            state_d = ST_SEND;
            cnt_d   = '0;
        end else if (do_out) begin
            if (out_last) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + p_cnt_nbits'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/vc_msg_serializer.sv
// Wide-to-narrow val/rdy serializer: holds one p_in_nbits message and emits it
// LSB chunk first as p_out_nbits chunks, flagging the final chunk.
module vc_msg_serializer
    import vc_serdes_pkg::*;
#(
    parameter int unsigned p_in_nbits  = 32,
    parameter int unsigned p_out_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_in_nbits-1:0]  in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_out_nbits-1:0] out_msg,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned c_nchunks   = serdes_nchunks(p_in_nbits, p_out_nbits);
    localparam int unsigned c_cnt_nbits = serdes_cnt_nbits(c_nchunks);
    localparam int unsigned c_sr_nbits  = c_nchunks * p_out_nbits;

    logic                  load_en;
    logic                  shift_en;
    logic [c_sr_nbits-1:0] sr_q, sr_d;

    vc_msg_serializer_ctrl #(
        .p_nchunks   (c_nchunks),
        .p_cnt_nbits (c_cnt_nbits)
    ) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .busy     (busy),
        .load_en  (load_en),
        .shift_en (shift_en)
    );

    // Loading zero-extends the message to a whole number of chunks.
    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = c_sr_nbits'(in_msg);
        end else if (shift_en) begin
            sr_d = sr_q >> p_out_nbits;
        end
    end

    // NOTE: the shift register is a single datapath word, not a memory array,
    // so it is reset to keep out_msg at zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_msg = sr_q[p_out_nbits-1:0];

    a_ctrl_known: assert property (@(posedge clk) disable iff (!reset_n)
        !$isunknown({in_val, out_rdy}))
        else $error("in_val/out_rdy unknown");

    a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (out_val && !out_rdy) |=> (out_val && $stable(out_msg)))
        else $error("out_msg changed while stalled");

endmodule

// File: tb/tb_vc_msg_serializer.sv
// Directed bench for vc_msg_serializer in three widths: 32->8, 20->8, 32->32.
module tb_vc_msg_serializer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // 32 -> 8
    logic        a_in_val = 1'b0, a_in_rdy, a_out_val, a_out_rdy = 1'b0, a_out_last, a_busy;
    logic [31:0] a_in_msg = '0;
    logic [7:0]  a_out_msg;
    // 20 -> 8
    logic        b_in_val = 1'b0, b_in_rdy, b_out_val, b_out_rdy = 1'b0, b_out_last, b_busy;
    logic [19:0] b_in_msg = '0;
    logic [7:0]  b_out_msg;
    // 32 -> 32
    logic        c_in_val = 1'b0, c_in_rdy, c_out_val, c_out_rdy = 1'b0, c_out_last, c_busy;
    logic [31:0] c_in_msg = '0;
    logic [31:0] c_out_msg;

    vc_msg_serializer #(.p_in_nbits(32), .p_out_nbits(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
        .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg), .out_last(a_out_last),
        .busy(a_busy));

    vc_msg_serializer #(.p_in_nbits(20), .p_out_nbits(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
        .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg), .out_last(b_out_last),
        .busy(b_busy));

    vc_msg_serializer #(.p_in_nbits(32), .p_out_nbits(32)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_val(c_in_val), .in_rdy(c_in_rdy), .in_msg(c_in_msg),
        .out_val(c_out_val), .out_rdy(c_out_rdy), .out_msg(c_out_msg), .out_last(c_out_last),
        .busy(c_busy));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on dut_a: drive in the low phase, then compare registered outputs.
    task automatic a_cycle(input string tag, input logic iv, input logic [31:0] im,
                           input logic ordy, input logic ev, input logic [7:0] em,
                           input logic el, input logic erdy);
        @(negedge clk);
        a_in_val  = iv;
        a_in_msg  = im;
        a_out_rdy = ordy;
        #1;
        check({tag, " out_val"}, 32'(a_out_val), 32'(ev));
        check({tag, " busy"},    32'(a_busy),    32'(ev));
        check({tag, " in_rdy"},  32'(a_in_rdy),  32'(erdy));
        check({tag, " out_last"},32'(a_out_last),32'(el));
        if (ev) check({tag, " out_msg"}, 32'(a_out_msg), 32'(em));
    endtask

    typedef struct {
        logic        in_val;
        logic [31:0] in_msg;
        logic        out_rdy;
        logic        exp_val;
        logic [7:0]  exp_msg;
        logic        exp_last;
        logic        exp_in_rdy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    // Model for the 32->32 run: a single holding slot with pipelined accept.
    bit          m_hold;
    logic [31:0] m_msg;
    logic [31:0] exp_q[$];
    logic [31:0] next_msg;
    bit          pending;
    int          sent, rcvd, cyc;
    bit          m_rdy;

    initial begin
        // in_msg FFFFFFFF on idle-valid rows stands in for don't-care data.
        vecs[0]  = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h88, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst in_rdy",  32'(a_in_rdy),  32'h1);
        check("rst out_val", 32'(a_out_val), 32'h0);
        check("rst busy",    32'(a_busy),    32'h0);
        check("rst out_msg", 32'(a_out_msg), 32'h0);
        reset_n = 1'b1;

        // Basic, stall, and back-to-back sequences on dut_a.
        for (int i = 0; i < NV; i++) begin
            a_cycle($sformatf("vec%0d", i), vecs[i].in_val, vecs[i].in_msg, vecs[i].out_rdy,
                    vecs[i].exp_val, vecs[i].exp_msg, vecs[i].exp_last, vecs[i].exp_in_rdy);
        end

        // Async reset after two chunks, then a fresh message.
        a_cycle("abort acc", 1'b1, 32'h12345678, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        a_cycle("abort c0",  1'b0, 32'h0,        1'b1, 1'b1, 8'h78, 1'b0, 1'b0);
        a_cycle("abort c1",  1'b0, 32'h0,        1'b1, 1'b1, 8'h56, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort out_val",  32'(a_out_val),  32'h0);
        check("abort out_last", 32'(a_out_last), 32'h0);
        check("abort busy",     32'(a_busy),     32'h0);
        check("abort in_rdy",   32'(a_in_rdy),   32'h1);
        check("abort out_msg",  32'(a_out_msg),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        a_cycle("post-rst idle", 1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        a_cycle("beef acc",      1'b1, 32'h0000BEEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        a_cycle("beef c0",       1'b0, 32'h0,        1'b1, 1'b1, 8'hEF, 1'b0, 1'b0);
        a_cycle("beef c1",       1'b0, 32'h0,        1'b1, 1'b1, 8'hBE, 1'b0, 1'b0);
        a_cycle("beef c2",       1'b0, 32'h0,        1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        a_cycle("beef c3",       1'b0, 32'h0,        1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        a_cycle("beef idle",     1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Partial last chunk: 20-bit message in 8-bit chunks.
        @(negedge clk);
        b_in_val = 1'b1; b_in_msg = 20'hABCDE; b_out_rdy = 1'b1;
        #1 check("b acc in_rdy", 32'(b_in_rdy), 32'h1);
        @(negedge clk);
        b_in_val = 1'b0;
        #1 check("b c0 msg", 32'(b_out_msg), 32'hDE);
        check("b c0 val", 32'(b_out_val), 32'h1);
        check("b c0 last", 32'(b_out_last), 32'h0);
        @(negedge clk);
        #1 check("b c1 msg", 32'(b_out_msg), 32'hBC);
        check("b c1 last", 32'(b_out_last), 32'h0);
        @(negedge clk);
        #1 check("b c2 msg", 32'(b_out_msg), 32'h0A);
        check("b c2 last", 32'(b_out_last), 32'h1);
        @(negedge clk);
        #1 check("b idle val", 32'(b_out_val), 32'h0);

        // Single-chunk mode with random handshakes.
        m_hold = 0; m_msg = '0; pending = 0; sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 100 && cyc < 3000) begin
            @(negedge clk);
            if (!pending && sent < 100 && $urandom_range(0, 9) < 7) begin
                next_msg = $urandom;
                pending  = 1;
            end
            c_in_val  = pending;
            c_in_msg  = pending ? next_msg : 32'hFFFFFFFF;
            c_out_rdy = ($urandom_range(0, 9) < 6);
            #1;
            m_rdy = !m_hold || c_out_rdy;
            check("c out_val", 32'(c_out_val), 32'(m_hold));
            check("c in_rdy",  32'(c_in_rdy),  32'(m_rdy));
            if (m_hold) begin
                check("c out_msg",  c_out_msg,         m_msg);
                check("c out_last", 32'(c_out_last),   32'h1);
            end
            if (m_hold && c_out_rdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                rcvd++;
                m_hold = 0;
            end
            if (pending && m_rdy) begin
                m_hold  = 1;
                m_msg   = next_msg;
                exp_q.push_back(next_msg);
                pending = 0;
                sent++;
            end
            cyc++;
        end
        check("c msgs received", 32'(rcvd), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
